// File: rtl/check_data_trace.sv
// check_data_trace: debug probe unit for the pipeline CPU.
// Provides a registered live view of any probe channel and a triggered
// trace buffer that records one channel around a value/mask trigger event.
module check_data_trace #(
  parameter int NUM_CH = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH*DATA_W-1:0] probe_bus,
  input  logic [ADDR_W-1:0]        check_addr,
  output logic [DATA_W-1:0]        check_data,
  input  logic [ADDR_W-1:0]        cap_ch,
  input  logic                     cap_en,
  input  logic                     arm,
  input  logic [ADDR_W-1:0]        trig_ch,
  input  logic [DATA_W-1:0]        trig_val,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [PTR_W-1:0]         post_cnt,
  input  logic [PTR_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic [PTR_W:0]           fill,
  output logic [PTR_W-1:0]         trig_off,
  output logic [1:0]               state,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  // Channel mux; selects beyond the populated channels read as zero.
  function automatic logic [DATA_W-1:0] pick(input logic [NUM_CH*DATA_W-1:0] bus,
                                             input logic [ADDR_W-1:0] sel);
    pick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == ADDR_W'(i)) pick = bus[i*DATA_W +: DATA_W];
    end
  endfunction

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W:0]      fill_q, fill_d;
  logic [PTR_W-1:0]    rem_q;
  logic [PTR_W-1:0]    post_lat;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   live_val, cap_val, trig_sel;
  logic                hit;
  logic                do_sample, load_rem, dec_rem, clear, enter_done;
  logic [PTR_W-1:0]    post_sel;
  logic [PTR_W:0]      trig_off_full;
  logic [PTR_W-1:0]    oldest, rd_addr;
  logic                rd_valid;

  // Channel selection for live view, capture and trigger comparison.
  always_comb begin
    live_val = pick(probe_bus, check_addr);
    cap_val  = pick(probe_bus, cap_ch);
    trig_sel = pick(probe_bus, trig_ch);
    hit      = (((trig_sel ^ trig_val) & trig_mask) == '0);
  end

  // Capture FSM next state; arm overrides every other transition.
  always_comb begin
    state_d    = state_q;
    do_sample  = 1'b0;
    load_rem   = 1'b0;
    dec_rem    = 1'b0;
    clear      = 1'b0;
    enter_done = 1'b0;
    if (arm) begin
      state_d = ARMED;
      clear   = 1'b1;
    end else begin
      case (state_q)
        ARMED: begin
          if (cap_en) begin
            do_sample = 1'b1;
            if (hit) begin
              load_rem = 1'b1;
              if (post_cnt == '0) begin
                state_d    = DONE;
                enter_done = 1'b1;
              end else begin
                state_d = POST;
              end
            end
          end
        end
        POST: begin
          if (cap_en) begin
            do_sample = 1'b1;
            dec_rem   = 1'b1;
            if (rem_q == PTR_W'(1)) begin
              state_d    = DONE;
              enter_done = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Fill count after this cycle and trigger position for entry into DONE.
  always_comb begin
    fill_d = fill_q;
    if (clear) fill_d = '0;
    else if (do_sample && (fill_q != FULL)) fill_d = fill_q + (PTR_W+1)'(1);
    post_sel      = (state_q == ARMED) ? post_cnt : post_lat;
    trig_off_full = fill_d - (PTR_W+1)'(1) - {1'b0, post_sel};
  end

  // Readout address: oldest entry is slot 0 until the ring has wrapped.
  always_comb begin
    oldest   = fill_q[PTR_W] ? wr_ptr : '0;
    rd_addr  = oldest + rd_idx;
    rd_valid = ({1'b0, rd_idx} < fill_q);
  end

  // FSM, pointers, counters and trigger bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      fill_q   <= '0;
      rem_q    <= '0;
      post_lat <= '0;
      trig_off <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      if (clear) wr_ptr <= '0;
      else if (do_sample) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load_rem) begin
        rem_q    <= post_cnt;
        post_lat <= post_cnt;
      end else if (dec_rem) begin
        rem_q <= rem_q - PTR_W'(1);
      end
      if (enter_done) trig_off <= trig_off_full[PTR_W-1:0];
    end
  end

  // Trace RAM write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (do_sample) mem[wr_ptr] <= cap_val;
  end

  // Registered live view and buffer readout (read-before-write on the RAM).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      check_data <= '0;
      rd_data    <= '0;
    end else begin
      check_data <= live_val;
      if (clear || !rd_valid) rd_data <= '0;
      else rd_data <= mem[rd_addr];
    end
  end

  assign fill  = fill_q;
  assign state = state_q;
  assign done  = (state_q == DONE);

endmodule
